// File: rtl/ecc_54_scrub_ctrl_pkg.sv
// Shared types and constants for the 54-bit ECC scrubber.
// The check matrix is an odd-weight-column SECDED code: data columns have
// weight 3 or 5 and each parity bit has its own unit column. Any single flip
// therefore gives an odd syndrome and any double flip gives an even, non-zero
// syndrome.
package ecc_54_scrub_ctrl_pkg;

  localparam int DATA_W = 54;
  localparam int PAR_W  = 7;
  localparam int WORD_W = 61;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    CHK,
    WB
  } scrub_state_t;

  // Check-matrix column for each data bit. The first 35 are all weight-3
  // patterns and the remaining 19 are weight-5 patterns.
  localparam logic [PAR_W-1:0] H_COL [DATA_W] = '{
    7'd67,  7'd69,  7'd70,  7'd73,  7'd74,  7'd76,  7'd81,  7'd82,
    7'd84,  7'd88,  7'd97,  7'd98,  7'd100, 7'd104, 7'd112, 7'd7,
    7'd11,  7'd13,  7'd14,  7'd19,  7'd21,  7'd22,  7'd25,  7'd26,
    7'd28,  7'd35,  7'd37,  7'd38,  7'd41,  7'd42,  7'd44,  7'd49,
    7'd50,  7'd52,  7'd56,  7'd31,  7'd47,  7'd55,  7'd59,  7'd61,
    7'd62,  7'd79,  7'd87,  7'd91,  7'd93,  7'd94,  7'd103, 7'd107,
    7'd109, 7'd110, 7'd115, 7'd117, 7'd118, 7'd121
  };

endpackage

// File: rtl/ecc_54_cal.sv
// ECC encoder/checker for one 54-bit word. With bypass=1 it only generates
// parity; with bypass=0 it also computes the syndrome, corrects a single
// data-bit flip and classifies the error.
module ecc_54_cal
  import ecc_54_scrub_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAR_W-1:0]  parity_in,
  input  logic              bypass,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  parity_out,
  output logic              sbit_err,
  output logic              dbit_err
);

  logic [PAR_W-1:0]  syndrome;
  logic [DATA_W-1:0] flip;
  logic              par_only;

  // Parity generation: each set data bit contributes its matrix column
  always_comb begin
    parity_out = '0;
    for (int i = 0; i < DATA_W; i++) begin
      parity_out = parity_out ^ ({PAR_W{data_in[i]}} & H_COL[i]);
    end
  end

  assign syndrome = bypass ? '0 : (parity_out ^ parity_in);

  // A data bit is flipped back when the syndrome equals its column
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
    assign flip[gi] = (syndrome == H_COL[gi]);
  end

  // Exactly one syndrome bit set means a stored parity bit was hit
  assign par_only = (syndrome != '0) && ((syndrome & (syndrome - PAR_W'(1))) == '0);

  assign data_out = data_in ^ flip;
  assign sbit_err = (|flip) | par_only;
  assign dbit_err = (syndrome != '0) & ~sbit_err;

endmodule

// File: rtl/ecc_54_scrub_ctrl.sv
// Background memory scrubber: periodically reads each word, corrects and
// writes back single-bit errors, and reports uncorrectable words. Yields the
// memory port to the functional side whenever func_req is high.
module ecc_54_scrub_ctrl
  import ecc_54_scrub_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  input  logic [CNT_WIDTH-1:0]  interval,
  input  logic                  clr_cnt,
  input  logic                  func_req,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [ADDR_WIDTH-1:0] dbit_addr,
  output logic                  dbit_irq,
  output logic                  pass_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  scrub_state_t          state;
  logic [CNT_WIDTH-1:0]  ivl_cnt;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [DATA_W-1:0]     corr_data;

  logic [DATA_W-1:0]     cal_data_in;
  logic [DATA_W-1:0]     cal_data_out;
  logic [PAR_W-1:0]      cal_parity;
  logic                  cal_bypass;
  logic                  cal_sbit;
  logic                  cal_dbit;

  logic                  decode;
  logic                  word_done;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  sbit_inc;
  logic                  dbit_inc;

  // One shared checker: read data while checking, latched correction while
  // writing back (parity regeneration only)
  assign cal_bypass  = (state == WB);
  assign cal_data_in = cal_bypass ? corr_data : mem_rdata[DATA_W-1:0];

  ecc_54_cal u_cal (
    .data_in    (cal_data_in),
    .parity_in  (mem_rdata[WORD_W-1:DATA_W]),
    .bypass     (cal_bypass),
    .data_out   (cal_data_out),
    .parity_out (cal_parity),
    .sbit_err   (cal_sbit),
    .dbit_err   (cal_dbit)
  );

  // Read data arrives the cycle after the select register drops, so CHK
  // only decodes once mem_cs has been released
  assign decode    = (state == CHK) && !mem_cs;
  assign word_done = (decode && !cal_sbit) || ((state == WB) && !func_req);
  assign wrap      = (scrub_addr == LAST_ADDR);
  assign next_addr = wrap ? '0 : scrub_addr + ADDR_WIDTH'(1);
  assign sbit_inc  = decode && cal_sbit;
  assign dbit_inc  = decode && cal_dbit;
  assign busy      = (state != IDLE);

  // Scrub sequencer with registered memory strobes and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ivl_cnt    <= '0;
      scrub_addr <= '0;
      corr_data  <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dbit_addr  <= '0;
      dbit_irq   <= 1'b0;
      pass_done  <= 1'b0;
    end else begin
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      dbit_irq  <= 1'b0;
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scrub_en) begin
            state   <= WAIT;
            ivl_cnt <= interval;
          end
        end
        WAIT: begin
          if (!scrub_en) begin
            state <= IDLE;
          end else if (ivl_cnt == '0) begin
            state <= RD;
          end else begin
            ivl_cnt <= ivl_cnt - CNT_WIDTH'(1);
          end
        end
        RD: begin
          if (!func_req) begin
            mem_cs   <= 1'b1;
            mem_addr <= scrub_addr;
            state    <= CHK;
          end
        end
        CHK: begin
          if (decode) begin
            if (cal_sbit) begin
              corr_data <= cal_data_out;
              state     <= WB;
            end else if (cal_dbit) begin
              dbit_addr <= scrub_addr;
              dbit_irq  <= 1'b1;
            end
          end
        end
        WB: begin
          if (!func_req) begin
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= scrub_addr;
            mem_wdata <= {cal_parity, corr_data};
          end
        end
        default: state <= IDLE;
      endcase
      if (word_done) begin
        scrub_addr <= next_addr;
        pass_done  <= wrap;
        ivl_cnt    <= interval;
        state      <= scrub_en ? WAIT : IDLE;
      end
    end
  end

  // Corrected-error counter: saturating, clear wins but keeps a same-cycle hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt <= '0;
    end else if (clr_cnt) begin
      sbit_cnt <= CNT_WIDTH'(sbit_inc);
    end else if (sbit_inc && !(&sbit_cnt)) begin
      sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
    end
  end

  // Uncorrectable-error counter: same saturate/clear behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbit_cnt <= '0;
    end else if (clr_cnt) begin
      dbit_cnt <= CNT_WIDTH'(dbit_inc);
    end else if (dbit_inc && !(&dbit_cnt)) begin
      dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_54_scrub_ctrl.sv
// Self-checking bench for ecc_54_scrub_ctrl: expected memory accesses are
// queued as each scenario is set up and popped as the DUT issues them.
module tb_ecc_54_scrub_ctrl;
  import ecc_54_scrub_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DP = 4;
  localparam int CW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [60:0]   wdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic [CW-1:0] interval = '0;
  logic          clr_cnt = 1'b0;
  logic          func_req = 1'b0;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [60:0]   mem_wdata;
  logic [60:0]   mem_rdata;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic [AW-1:0] dbit_addr;
  logic          dbit_irq, pass_done, busy;

  logic [60:0]   img [DP];
  acc_t          exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cs = 0;
  int cs_gap = 0;
  int pd_cnt = 0;
  int exp_pd = 0;
  int irq_cnt = 0;
  int exp_addr = 0;
  logic [6:0] last_syn = '0;

  ecc_54_scrub_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .interval(interval),
    .clr_cnt(clr_cnt), .func_req(func_req), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .dbit_addr(dbit_addr),
    .dbit_irq(dbit_irq), .pass_done(pass_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory image: read data is registered, valid the cycle after the read
  always @(posedge clk) begin
    if (mem_cs && !mem_we) mem_rdata <= img[mem_addr[1:0]];
  end

  // One clock; observe outputs on the falling edge and consume the scoreboard
  task automatic cycle();
    acc_t e;
    @(negedge clk);
    cyc++;
    if (mem_cs) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL access: unexpected we=%0b addr=%0d, required no access", mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL access: got we=%0b addr=%0d wdata=%h, required we=%0b addr=%0d wdata=%h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
        end
      end
      if (!mem_we) begin
        cs_gap  = cyc - last_cs;
        last_cs = cyc;
      end
    end
    if (pass_done) begin
      pd_cnt++;
      n_vec++;
      if (mem_addr !== AW'(DP - 1)) begin
        n_err++;
        $display("FAIL pass_done_addr: got %0d, required %0d", mem_addr, DP - 1);
      end
    end
    if (dbit_irq) irq_cnt++;
    if (dut.state == CHK && !mem_cs) last_syn = dut.u_cal.syndrome;
  endtask

  // Queue one word visit: a read and, for a correctable word, a zero write-back
  task automatic push_word(bit wr);
    acc_t a;
    a.we = 1'b0;
    a.addr = AW'(exp_addr);
    a.wdata = '0;
    exp_q.push_back(a);
    if (wr) begin
      a.we = 1'b1;
      exp_q.push_back(a);
    end
    if (exp_addr == DP - 1) begin
      exp_pd++;
      exp_addr = 0;
    end else begin
      exp_addr++;
    end
  endtask

  // Run until every queued access is seen, then disable and wait for idle
  task automatic run_expect(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout: %0d accesses missing, required 0", exp_q.size());
      exp_q.delete();
    end
    scrub_en = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({mem_cs, mem_we, dbit_irq, pass_done, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, required 00000", {mem_cs, mem_we, dbit_irq, pass_done, busy});
    end
    n_vec++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0 || dbit_addr !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d, required 0/0/0", sbit_cnt, dbit_cnt, dbit_addr);
    end
    rst_n = 1'b1;
    cycle();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%0b, required 0", busy);
    end
    $display("reset: sbit=%0d dbit=%0d busy=%0b", sbit_cnt, dbit_cnt, busy);
  endtask

  task automatic test_clean();
    for (int i = 0; i < DP; i++) img[i] = '0;
    interval = '0;
    push_word(0);
    push_word(0);
    scrub_en = 1'b1;
    run_expect(40);
    n_vec++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0) begin
      n_err++;
      $display("FAIL clean_cnt: got %0d/%0d, required 0/0", sbit_cnt, dbit_cnt);
    end
    n_vec++;
    if (dut.scrub_addr !== AW'(exp_addr)) begin
      n_err++;
      $display("FAIL clean_addr: got %0d, required %0d", dut.scrub_addr, exp_addr);
    end
    $display("clean: next addr %0d", dut.scrub_addr);
  endtask

  task automatic test_interval();
    interval = 4'd5;
    push_word(0);
    push_word(0);
    scrub_en = 1'b1;
    run_expect(60);
    n_vec++;
    if (cs_gap !== 9) begin
      n_err++;
      $display("FAIL interval_gap: got %0d cycles, required 9", cs_gap);
    end
    n_vec++;
    if (pd_cnt !== exp_pd) begin
      n_err++;
      $display("FAIL interval_pass: got %0d, required %0d", pd_cnt, exp_pd);
    end
    interval = '0;
    $display("interval: gap %0d pass_done %0d", cs_gap, pd_cnt);
  endtask

  task automatic test_sbit_data();
    img[exp_addr] = {7'h00, 54'h1};
    push_word(1);
    scrub_en = 1'b1;
    run_expect(40);
    n_vec++;
    if (last_syn !== 7'b1000011) begin
      n_err++;
      $display("FAIL sbit_syn: got %b, required 1000011", last_syn);
    end
    n_vec++;
    if (sbit_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL sbit_cnt: got %0d, required 1", sbit_cnt);
    end
    for (int i = 0; i < DP; i++) img[i] = '0;
    $display("sbit_data: syn %b sbit %0d", last_syn, sbit_cnt);
  endtask

  task automatic test_parity();
    img[exp_addr] = {7'b0000001, 54'h0};
    push_word(1);
    scrub_en = 1'b1;
    run_expect(40);
    n_vec++;
    if (last_syn !== 7'b0000001) begin
      n_err++;
      $display("FAIL par_syn: got %b, required 0000001", last_syn);
    end
    n_vec++;
    if (sbit_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL par_cnt: got %0d, required 2", sbit_cnt);
    end
    for (int i = 0; i < DP; i++) img[i] = '0;
    $display("parity: syn %b sbit %0d", last_syn, sbit_cnt);
  endtask

  task automatic test_dbit();
    int a;
    a = exp_addr;
    img[a] = {7'h00, 54'h3};
    push_word(0);
    scrub_en = 1'b1;
    run_expect(40);
    n_vec++;
    if (last_syn !== 7'b0000110) begin
      n_err++;
      $display("FAIL dbit_syn: got %b, required 0000110", last_syn);
    end
    n_vec++;
    if (dbit_cnt !== 4'd1 || dbit_addr !== AW'(a)) begin
      n_err++;
      $display("FAIL dbit_cnt_addr: got %0d/%0d, required 1/%0d", dbit_cnt, dbit_addr, a);
    end
    n_vec++;
    if (irq_cnt !== 1) begin
      n_err++;
      $display("FAIL dbit_irq: got %0d pulse cycles, required 1", irq_cnt);
    end
    for (int i = 0; i < DP; i++) img[i] = '0;
    $display("dbit: syn %b dbit %0d addr %0d", last_syn, dbit_cnt, dbit_addr);
  endtask

  task automatic test_func_req();
    img[exp_addr] = {7'h00, 54'h1};
    func_req = 1'b1;
    scrub_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_vec++;
      if (mem_cs !== 1'b0) begin
        n_err++;
        $display("FAIL rd_stall: mem_cs=%0b, required 0", mem_cs);
      end
    end
    push_word(1);
    func_req = 1'b0;
    cycle();
    n_vec++;
    if (mem_cs !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rd_release: cs/we=%0b%0b, required 10", mem_cs, mem_we);
    end
    func_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_vec++;
      if (mem_cs !== 1'b0) begin
        n_err++;
        $display("FAIL wb_stall: mem_cs=%0b, required 0", mem_cs);
      end
    end
    n_vec++;
    if (dut.state !== WB) begin
      n_err++;
      $display("FAIL wb_state: got %0d, required %0d", dut.state, WB);
    end
    func_req = 1'b0;
    cycle();
    n_vec++;
    if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL wb_release: cs/we=%0b%0b, required 11", mem_cs, mem_we);
    end
    run_expect(20);
    n_vec++;
    if (sbit_cnt !== 4'd3 || pd_cnt !== exp_pd) begin
      n_err++;
      $display("FAIL func_cnt: got sbit %0d pass %0d, required 3 %0d", sbit_cnt, pd_cnt, exp_pd);
    end
    for (int i = 0; i < DP; i++) img[i] = '0;
    $display("func_req: sbit %0d pass_done %0d", sbit_cnt, pd_cnt);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DP; i++) img[i] = {7'h00, 54'h1};
    for (int i = 0; i < 13; i++) push_word(1);
    scrub_en = 1'b1;
    run_expect(300);
    n_vec++;
    if (sbit_cnt !== 4'hF) begin
      n_err++;
      $display("FAIL saturate: got %0d, required 15", sbit_cnt);
    end
    n_vec++;
    if (pd_cnt !== exp_pd) begin
      n_err++;
      $display("FAIL sat_pass: got %0d, required %0d", pd_cnt, exp_pd);
    end
    $display("saturate: sbit %0d pass_done %0d", sbit_cnt, pd_cnt);
  endtask

  task automatic test_clr();
    int n = 0;
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    cycle();
    n_vec++;
    if (sbit_cnt !== '0 || dbit_cnt !== '0) begin
      n_err++;
      $display("FAIL clr_idle: got %0d/%0d, required 0/0", sbit_cnt, dbit_cnt);
    end
    push_word(1);
    scrub_en = 1'b1;
    while (exp_q.size() == 2 && n < 20) begin
      cycle();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 1) begin
      n_err++;
      $display("FAIL clr_read: %0d accesses pending, required 1", exp_q.size());
    end
    cycle();
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    run_expect(20);
    n_vec++;
    if (sbit_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL clr_inc: got %0d, required 1", sbit_cnt);
    end
    $display("clr: sbit %0d dbit %0d", sbit_cnt, dbit_cnt);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    push_word(1);
    scrub_en = 1'b1;
    while (exp_q.size() == 2 && n < 20) begin
      cycle();
      n++;
    end
    func_req = 1'b1;
    repeat (4) cycle();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_cs !== 1'b0 || busy !== 1'b0 || sbit_cnt !== '0) begin
      n_err++;
      $display("FAIL mid_reset: cs/busy/sbit=%0b/%0b/%0d, required 0/0/0", mem_cs, busy, sbit_cnt);
    end
    exp_q.delete();
    cycle();
    for (int i = 0; i < DP; i++) img[i] = '0;
    exp_addr = 0;
    func_req = 1'b0;
    rst_n = 1'b1;
    push_word(0);
    run_expect(40);
    n_vec++;
    if (dut.scrub_addr !== AW'(1)) begin
      n_err++;
      $display("FAIL mid_resume: got %0d, required 1", dut.scrub_addr);
    end
    $display("reset_mid: resumed, next addr %0d", dut.scrub_addr);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_interval();
    test_sbit_data();
    test_parity();
    test_dbit();
    test_func_req();
    test_saturate();
    test_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_54_scrub_ctrl.md
ECC_54_SCRUB_CTRL -- requirements
Module: ecc_54_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of scrubbed words (≤ 2^ADDR_WIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the error counters and the interval.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-005 SHALL have ports:
- scrub_en in 1: level enable for scrubbing.
- interval in CNT_WIDTH: idle cycles between word visits.
- clr_cnt in 1: pulse that clears both error counters.
- func_req in 1: the functional port owns the memory this cycle; the scrubber SHALL NOT drive mem_cs.
- mem_cs out 1: memory select.
- mem_we out 1: write enable.
- mem_addr out ADDR_WIDTH: word address.
- mem_wdata out 61: write word, {parity[6:0], data[53:0]}.
- mem_rdata in 61: read word, same format, valid exactly 1 cycle after a read.
- sbit_cnt out CNT_WIDTH: corrected-error count.
- dbit_cnt out CNT_WIDTH: uncorrectable-error count.
- dbit_addr out ADDR_WIDTH: address of the last uncorrectable word.
- dbit_irq out 1: one-cycle pulse on an uncorrectable error.
- pass_done out 1: one-cycle pulse when the last word of a full pass completes.
- busy out 1: high in any state except IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RD, CHK, WB.
REQ-007 IDLE -> WAIT when scrub_en=1; on entry, load the interval counter with interval.
REQ-008 WAIT SHALL decrement the interval counter each cycle and go to RD on the cycle the counter equals 0; interval=0 SHALL give WAIT for exactly 1 cycle.
REQ-009 RD: when func_req=0, drive mem_cs=1, mem_we=0, mem_addr=scrub_addr, and go to CHK; when func_req=1, drive mem_cs=0 and stay in RD.
REQ-010 CHK: decode mem_rdata through the check datapath with bypass=0.
- No error: advance the address and go to WAIT.
- sbit_err: sbit_cnt++, latch the corrected data, go to WB.
- dbit_err: dbit_cnt++, dbit_addr<=scrub_addr, dbit_irq=1 for one cycle, no writeback, advance the address, go to WAIT.
REQ-011 WB: feed the latched corrected data to the same decoder with bypass=1 and take parity_out as the new parity. When func_req=0, drive mem_cs=1, mem_we=1, mem_wdata={parity_out, corrected}, advance the address, and go to WAIT; otherwise stay in WB.
REQ-012 A syndrome with a single parity bit set SHALL count as sbit_err and SHALL be written back; the data is unchanged and the parity is regenerated.
REQ-013 Address advance: scrub_addr==DEPTH-1 wraps to 0 and pulses pass_done in the same cycle; otherwise scrub_addr increments.
REQ-014 scrub_en=0 in WAIT SHALL go to IDLE on the next cycle; in RD, CHK or WB the current word SHALL complete first, then the FSM goes to IDLE. scrub_addr SHALL be retained, so a re-enable resumes from it.
REQ-015 Counters SHALL saturate at all-ones. clr_cnt together with an increment in the same cycle SHALL yield 1.
REQ-016 mem_cs, mem_we, dbit_irq and pass_done SHALL be registered outputs; mem_wdata and mem_addr SHALL be don't-care while mem_cs=0.

Reset
REQ-017 While rst_n=0: the FSM is in IDLE and all outputs, counters, scrub_addr, the interval counter and the latched data are 0.
REQ-018 Reset deassertion mid-operation SHALL restart from IDLE at address 0; no partial write SHALL be issued.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, DATA_W=54, PAR_W=7 and WORD_W=61.
REQ-020 SHALL instantiate exactly one ecc_54_cal, input-muxed between CHK (mem_rdata) and WB (latched corrected data).

Verification
REQ-021 Clean word: mem_rdata=61'h0, interval=0 -> no write, counters unchanged, next read at address+1.
REQ-022 Single data error: data=54'h1, parity=7'h00 -> syndrome 7'b1000011, sbit_cnt=1, write of 61'h0 to the same address.
REQ-023 Parity-only error: data=0, parity=7'b0000001 -> sbit_cnt=1, write of 61'h0.
REQ-024 Double error: data=54'h3, parity=0 -> syndrome 7'b0000110, dbit_cnt=1, dbit_irq pulse, dbit_addr=current address, no write.
REQ-025 func_req held high for 5 cycles during RD and WB -> mem_cs=0 throughout; the access issues on the first cycle func_req=0.
REQ-026 DEPTH=4, clean memory -> pass_done pulses with address 3 and the following read is at address 0; sbit_cnt preset to all-ones plus one more error -> stays all-ones.
